// File: rtl/ui_pkg.sv
// ui_pkg: shared codes for the telephone user interface.
//   state_e   - call-control FSM states (value appears on current_state)
//   item_e    - menu item codes (value appears on current_menu_item)
//   cmd_e     - call commands issued to the application layer
//   Inc*      - status codes arriving on inc_command
//   Txt*      - 16-character display strings, char 0 in bits [127:120]
package ui_pkg;

    typedef enum logic [2:0] {
        StInit     = 3'd0,
        StIdle     = 3'd1,
        StDialing  = 3'd2,
        StOutgoing = 3'd3,
        StIncoming = 3'd4,
        StBusy     = 3'd5,
        StWaitEnd  = 3'd6
    } state_e;

    typedef enum logic [5:0] {
        ItemWelcome    = 6'd0,
        ItemDatetime   = 6'd1,
        ItemCallNumber = 6'd2,
        ItemVoicemail  = 6'd3,
        ItemVolume     = 6'd4,
        ItemDial       = 6'd5,
        ItemCallerInfo = 6'd6,
        ItemAccept     = 6'd7,
        ItemReject     = 6'd8,
        ItemCallerId   = 6'd9,
        ItemEndCall    = 6'd10,
        ItemCalling    = 6'd11
    } item_e;

    typedef enum logic [2:0] {
        CmdNone   = 3'd0,
        CmdDial   = 3'd1,
        CmdAccept = 3'd2,
        CmdReject = 3'd3,
        CmdEnd    = 3'd4
    } cmd_e;

    localparam logic [2:0] IncNone      = 3'd0;
    localparam logic [2:0] IncConnected = 3'd1;
    localparam logic [2:0] IncIncoming  = 3'd5;
    localparam logic [2:0] IncEnded     = 3'd6;

    localparam logic [127:0] TxtWelcome    = "    WELCOME     ";
    localparam logic [127:0] TxtDatetime   = "DATE / TIME     ";
    localparam logic [127:0] TxtCallNumber = "CALL NUMBER     ";
    localparam logic [127:0] TxtVoicemail  = "VOICEMAIL       ";
    localparam logic [127:0] TxtVolume     = "VOLUME          ";
    localparam logic [127:0] TxtDial       = "DIAL NUMBER     ";
    localparam logic [127:0] TxtCallerInfo = "INCOMING CALL   ";
    localparam logic [127:0] TxtAccept     = "ACCEPT          ";
    localparam logic [127:0] TxtReject     = "REJECT          ";
    localparam logic [127:0] TxtCallerId   = "CALLER ID       ";
    localparam logic [127:0] TxtEndCall    = "END CALL        ";
    localparam logic [127:0] TxtCalling    = "CALLING...      ";
    localparam logic [127:0] TxtBlank      = "                ";

endpackage

// File: rtl/telephony_user_interface_if.sv
// telephony_user_interface_if: bundles the front-panel inputs, the application
// status/command signals and the display/datapath outputs of the UI.
//   master - environment side (drives panel inputs and inc_command)
//   slave  - the UI block (drives commands, status and display text)
interface telephony_user_interface_if;

    // Front panel
    logic s7, s6, s5, s4, s3, s2, s1, s0;
    logic b3, b2, b1, b0;
    logic enter, up, down, left, right;
    logic init;

    // Application layer
    logic [2:0]   inc_command;
    logic [2:0]   command;
    logic [15:0]  audio_in_data, audio_out_data, din, dout;
    logic [7:0]   inc_address;
    logic [7:0]   address;
    logic         ready;
    logic         voicemail_status;
    logic         voicemail_command;
    logic [7:0]   phn_num;
    logic [2:0]   current_state;
    logic [5:0]   current_menu_item;
    logic [4:0]   headphone_volume;

    // Display driver
    logic         disp_control;
    logic [127:0] string_data;

    modport master (
        output s7, s6, s5, s4, s3, s2, s1, s0,
        output b3, b2, b1, b0,
        output enter, up, down, left, right, init,
        output inc_command,
        input  command, audio_in_data, audio_out_data, din, dout, inc_address,
        input  address, ready, voicemail_status, voicemail_command, phn_num,
        input  current_state, current_menu_item, headphone_volume,
        input  disp_control, string_data
    );

    modport slave (
        input  s7, s6, s5, s4, s3, s2, s1, s0,
        input  b3, b2, b1, b0,
        input  enter, up, down, left, right, init,
        input  inc_command,
        output command, audio_in_data, audio_out_data, din, dout, inc_address,
        output address, ready, voicemail_status, voicemail_command, phn_num,
        output current_state, current_menu_item, headphone_volume,
        output disp_control, string_data
    );

endinterface

// File: rtl/ui_string_rom.sv
// ui_string_rom: combinational text lookup for the display line.
//   item - menu item code
//   text - 16 ASCII characters, char 0 in [127:120]; blank for unknown codes
module ui_string_rom
    import ui_pkg::*;
(
    input  item_e        item,
    output logic [127:0] text
);

    always_comb begin
        text = TxtBlank;
        unique case (item)
            ItemWelcome:    text = TxtWelcome;
            ItemDatetime:   text = TxtDatetime;
            ItemCallNumber: text = TxtCallNumber;
            ItemVoicemail:  text = TxtVoicemail;
            ItemVolume:     text = TxtVolume;
            ItemDial:       text = TxtDial;
            ItemCallerInfo: text = TxtCallerInfo;
            ItemAccept:     text = TxtAccept;
            ItemReject:     text = TxtReject;
            ItemCallerId:   text = TxtCallerId;
            ItemEndCall:    text = TxtEndCall;
            ItemCalling:    text = TxtCalling;
            default:        text = TxtBlank;
        endcase
    end

endmodule

// File: rtl/telephony_user_interface.sv
// telephony_user_interface: menu and call-control FSM for the FPGA telephone.
//   clk, reset - system clock, synchronous active-high reset (forces INIT)
//   bus        - slave side of telephony_user_interface_if: panel buttons and
//                switches, inc_command status in; command, call state, menu
//                item, volume, dialled number and display text out.
// All outputs are registered. Button actions fire on the clock edge that first
// samples the button high.
module telephony_user_interface
    import ui_pkg::*;
#(
    parameter int unsigned VOL_RESET = 16,
    parameter int unsigned VOL_MAX   = 31
) (
    input logic                       clk,
    input logic                       reset,
    telephony_user_interface_if.slave bus
);

    state_e       state_q, state_d;
    item_e        item_q, item_d;
    cmd_e         cmd_q, cmd_d;
    logic [7:0]   phn_q, phn_d;
    logic         vm_status_q, vm_status_d;
    logic         vm_cmd_q, vm_cmd_d;
    logic [4:0]   vol_q, vol_d;
    logic         ready_q;
    logic [127:0] text, string_q;
    logic         disp_q;

    logic [7:0] btn_now, btn_prev_q, btn_edge;
    logic       enter_e, up_e, down_e, left_e, right_e, b0_e, b1_e, init_e;
    logic [7:0] switches;
    logic       unused_buttons;

    assign btn_now  = {bus.init, bus.b1, bus.b0, bus.right, bus.left, bus.down, bus.up,
                       bus.enter};
    assign btn_edge = btn_now & ~btn_prev_q;
    assign {init_e, b1_e, b0_e, right_e, left_e, down_e, up_e, enter_e} = btn_edge;
    assign switches = {bus.s7, bus.s6, bus.s5, bus.s4, bus.s3, bus.s2, bus.s1, bus.s0};

    // b3/b2 are reserved
    assign unused_buttons = ^{bus.b3, bus.b2};

    ui_string_rom u_rom (
        .item (item_q),
        .text (text)
    );

    // Call-control FSM. inc_command always outranks buttons in the same cycle.
    always_comb begin
        state_d     = state_q;
        item_d      = item_q;
        cmd_d       = cmd_q;
        phn_d       = phn_q;
        vm_status_d = vm_status_q;
        vm_cmd_d    = 1'b0;
        unique case (state_q)
            StInit: begin
                if (enter_e || init_e) begin
                    state_d = StIdle;
                    item_d  = ItemDatetime;
                end
            end
            StIdle: begin
                if (bus.inc_command == IncIncoming) begin
                    state_d = StIncoming;
                    item_d  = ItemCallerInfo;
                    cmd_d   = CmdNone;
                end else if (item_q == ItemDatetime) begin
                    if (right_e) item_d = ItemCallNumber;
                end else if (item_q >= ItemCallNumber && item_q <= ItemVolume) begin
                    if (enter_e && item_q == ItemCallNumber) begin
                        state_d = StDialing;
                        item_d  = ItemDial;
                    end else if (enter_e && item_q == ItemVoicemail) begin
                        vm_cmd_d    = 1'b1;
                        vm_status_d = ~vm_status_q;
                    end else if (left_e) begin
                        item_d = ItemDatetime;
                    end else if (up_e) begin
                        item_d = (item_q == ItemCallNumber) ? ItemVolume
                                                            : item_e'(item_q - 6'd1);
                    end else if (down_e) begin
                        item_d = (item_q == ItemVolume) ? ItemCallNumber
                                                        : item_e'(item_q + 6'd1);
                    end
                end
            end
            StDialing: begin
                if (enter_e) begin
                    phn_d   = switches;
                    cmd_d   = CmdDial;
                    state_d = StOutgoing;
                    item_d  = ItemCalling;
                end else if (left_e) begin
                    state_d = StIdle;
                    item_d  = ItemCallNumber;
                end
            end
            StOutgoing: begin
                if (bus.inc_command == IncConnected) begin
                    state_d = StBusy;
                    item_d  = ItemCallerId;
                    cmd_d   = CmdNone;
                end else if (bus.inc_command == IncEnded) begin
                    state_d = StIdle;
                    item_d  = ItemDatetime;
                    cmd_d   = CmdNone;
                end else if (enter_e && item_q == ItemEndCall) begin
                    cmd_d   = CmdEnd;
                    state_d = StWaitEnd;
                end else if (up_e || down_e) begin
                    item_d = (item_q == ItemCalling) ? ItemEndCall : ItemCalling;
                end
            end
            StIncoming: begin
                if (bus.inc_command == IncEnded) begin
                    state_d = StIdle;
                    item_d  = ItemDatetime;
                    cmd_d   = CmdNone;
                end else if (enter_e && item_q == ItemAccept) begin
                    cmd_d   = CmdAccept;
                    state_d = StBusy;
                    item_d  = ItemCallerId;
                end else if (enter_e && item_q == ItemReject) begin
                    cmd_d   = CmdReject;
                    state_d = StIdle;
                    item_d  = ItemDatetime;
                end else if (down_e) begin
                    item_d = (item_q == ItemReject) ? ItemCallerInfo
                                                    : item_e'(item_q + 6'd1);
                end else if (up_e) begin
                    item_d = (item_q == ItemCallerInfo) ? ItemReject
                                                        : item_e'(item_q - 6'd1);
                end
            end
            StBusy: begin
                if (bus.inc_command == IncEnded) begin
                    state_d = StIdle;
                    item_d  = ItemDatetime;
                    cmd_d   = CmdNone;
                end else if (enter_e && item_q == ItemEndCall) begin
                    cmd_d   = CmdEnd;
                    state_d = StWaitEnd;
                end else if (up_e || down_e) begin
                    item_d = (item_q == ItemCallerId) ? ItemEndCall : ItemCallerId;
                end
            end
            StWaitEnd: begin
                if (bus.inc_command == IncEnded) begin
                    state_d = StIdle;
                    item_d  = ItemDatetime;
                    cmd_d   = CmdNone;
                end
            end
            default: begin
                state_d = StInit;
                item_d  = ItemWelcome;
            end
        endcase
    end

    // Volume steps are ignored in INIT and cancel out when both edges coincide.
    always_comb begin
        vol_d = vol_q;
        if (state_q != StInit) begin
            if (b1_e && !b0_e && vol_q < 5'(VOL_MAX)) begin
                vol_d = vol_q + 5'd1;
            end else if (b0_e && !b1_e && vol_q != 5'd0) begin
                vol_d = vol_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StInit;
            item_q      <= ItemWelcome;
            cmd_q       <= CmdNone;
            phn_q       <= 8'd0;
            vm_status_q <= 1'b0;
            vm_cmd_q    <= 1'b0;
            vol_q       <= 5'(VOL_RESET);
            ready_q     <= 1'b0;
            string_q    <= TxtWelcome;
            disp_q      <= 1'b0;
            btn_prev_q  <= btn_now;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            cmd_q       <= cmd_d;
            phn_q       <= phn_d;
            vm_status_q <= vm_status_d;
            vm_cmd_q    <= vm_cmd_d;
            vol_q       <= vol_d;
            ready_q     <= (state_d != StInit);
            // Text follows the item register by one cycle; strobe marks the update.
            string_q    <= text;
            disp_q      <= (text != string_q);
            btn_prev_q  <= btn_now;
        end
    end

    assign bus.command           = cmd_q;
    assign bus.current_state     = state_q;
    assign bus.current_menu_item = item_q;
    assign bus.address           = {2'b00, item_q};
    assign bus.ready             = ready_q;
    assign bus.voicemail_status  = vm_status_q;
    assign bus.voicemail_command = vm_cmd_q;
    assign bus.phn_num           = phn_q;
    assign bus.headphone_volume  = vol_q;
    assign bus.disp_control      = disp_q;
    assign bus.string_data       = string_q;
    assign bus.audio_in_data     = 16'd0;
    assign bus.audio_out_data    = 16'd0;
    assign bus.din               = 16'd0;
    assign bus.dout              = 16'd0;
    assign bus.inc_address       = 8'd0;

endmodule

// File: tb/tb_telephony_user_interface.sv
// tb_telephony_user_interface: directed scenario bench for the telephone UI.
module tb_telephony_user_interface;

    localparam int BtnEnter = 0;
    localparam int BtnUp    = 1;
    localparam int BtnDown  = 2;
    localparam int BtnLeft  = 3;
    localparam int BtnRight = 4;
    localparam int BtnB0    = 5;
    localparam int BtnB1    = 6;
    localparam int BtnInit  = 7;

    localparam logic [127:0] ExpWelcome  = "    WELCOME     ";
    localparam logic [127:0] ExpDatetime = "DATE / TIME     ";

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    telephony_user_interface_if bus ();

    telephony_user_interface #(
        .VOL_RESET (16),
        .VOL_MAX   (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            BtnEnter: bus.enter = v;
            BtnUp:    bus.up    = v;
            BtnDown:  bus.down  = v;
            BtnLeft:  bus.left  = v;
            BtnRight: bus.right = v;
            BtnB0:    bus.b0    = v;
            BtnB1:    bus.b1    = v;
            default:  bus.init  = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        tick();
        set_btn(which, 1'b0);
        tick();
    endtask

    task automatic pulse_inc(input logic [2:0] code);
        bus.inc_command = code;
        tick();
        bus.inc_command = 3'd0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (bus.current_state !== 3'd0) begin
            $display("FAIL reset_state got %0d want 0", bus.current_state); miscompares++;
        end
        vectors++;
        if (bus.current_menu_item !== 6'd0) begin
            $display("FAIL reset_item got %0d want 0", bus.current_menu_item); miscompares++;
        end
        vectors++;
        if (bus.command !== 3'd0) begin
            $display("FAIL reset_command got %0d want 0", bus.command); miscompares++;
        end
        vectors++;
        if (bus.headphone_volume !== 5'd16) begin
            $display("FAIL reset_volume got %0d want 16", bus.headphone_volume); miscompares++;
        end
        vectors++;
        if ({bus.ready, bus.disp_control, bus.voicemail_status, bus.voicemail_command}
            !== 4'b0000) begin
            $display("FAIL reset_flags got %b want 0000", {bus.ready, bus.disp_control,
                     bus.voicemail_status, bus.voicemail_command});
            miscompares++;
        end
        vectors++;
        if (bus.phn_num !== 8'd0 || bus.address !== 8'd0) begin
            $display("FAIL reset_phn_addr got %h/%h want 00/00", bus.phn_num, bus.address);
            miscompares++;
        end
        vectors++;
        if (bus.string_data !== ExpWelcome) begin
            $display("FAIL reset_text got %h want %h", bus.string_data, ExpWelcome);
            miscompares++;
        end
        vectors++;
        if ({bus.audio_in_data, bus.audio_out_data, bus.din, bus.dout, bus.inc_address}
            !== 72'd0) begin
            $display("FAIL reserved_outputs not zero"); miscompares++;
        end
    endtask

    task automatic test_enter_idle();
        press(BtnEnter);
        vectors++;
        if (bus.current_state !== 3'd1 || bus.current_menu_item !== 6'd1) begin
            $display("FAIL enter_idle got st %0d item %0d want 1 1", bus.current_state,
                     bus.current_menu_item);
            miscompares++;
        end
        vectors++;
        if (bus.ready !== 1'b1 || bus.command !== 3'd0) begin
            $display("FAIL enter_ready_cmd got %b %0d want 1 0", bus.ready, bus.command);
            miscompares++;
        end
        vectors++;
        if (bus.disp_control !== 1'b1 || bus.string_data !== ExpDatetime) begin
            $display("FAIL disp_strobe got %b %h want 1 %h", bus.disp_control,
                     bus.string_data, ExpDatetime);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.disp_control !== 1'b0) begin
            $display("FAIL disp_one_cycle got %b want 0", bus.disp_control); miscompares++;
        end
    endtask

    task automatic test_incoming_accept();
        press(BtnRight);
        vectors++;
        if (bus.current_menu_item !== 6'd2 || bus.address !== 8'd2) begin
            $display("FAIL idle_right got %0d/%0d want 2/2", bus.current_menu_item,
                     bus.address);
            miscompares++;
        end
        pulse_inc(3'd5);
        vectors++;
        if (bus.current_state !== 3'd4 || bus.current_menu_item !== 6'd6) begin
            $display("FAIL incoming got st %0d item %0d want 4 6", bus.current_state,
                     bus.current_menu_item);
            miscompares++;
        end
        press(BtnDown);
        vectors++;
        if (bus.current_menu_item !== 6'd7) begin
            $display("FAIL incoming_down got %0d want 7", bus.current_menu_item); miscompares++;
        end
        press(BtnEnter);
        vectors++;
        if (bus.current_state !== 3'd5 || bus.current_menu_item !== 6'd9 ||
            bus.command !== 3'd2) begin
            $display("FAIL accept got st %0d item %0d cmd %0d want 5 9 2", bus.current_state,
                     bus.current_menu_item, bus.command);
            miscompares++;
        end
    endtask

    task automatic test_busy_end();
        press(BtnDown);
        vectors++;
        if (bus.current_menu_item !== 6'd10) begin
            $display("FAIL busy_down got %0d want 10", bus.current_menu_item); miscompares++;
        end
        press(BtnEnter);
        vectors++;
        if (bus.current_state !== 3'd6 || bus.command !== 3'd4) begin
            $display("FAIL end_call got st %0d cmd %0d want 6 4", bus.current_state,
                     bus.command);
            miscompares++;
        end
        pulse_inc(3'd6);
        vectors++;
        if (bus.current_state !== 3'd1 || bus.current_menu_item !== 6'd1 ||
            bus.command !== 3'd0) begin
            $display("FAIL call_ended got st %0d item %0d cmd %0d want 1 1 0",
                     bus.current_state, bus.current_menu_item, bus.command);
            miscompares++;
        end
    endtask

    task automatic test_dial();
        press(BtnRight);
        press(BtnLeft);
        vectors++;
        if (bus.current_menu_item !== 6'd1) begin
            $display("FAIL menu_left got %0d want 1", bus.current_menu_item); miscompares++;
        end
        press(BtnRight);
        press(BtnEnter);
        vectors++;
        if (bus.current_state !== 3'd2 || bus.current_menu_item !== 6'd5) begin
            $display("FAIL dialing got st %0d item %0d want 2 5", bus.current_state,
                     bus.current_menu_item);
            miscompares++;
        end
        bus.s2 = 1'b1;
        press(BtnEnter);
        vectors++;
        if (bus.phn_num !== 8'h04 || bus.current_state !== 3'd3 || bus.command !== 3'd1 ||
            bus.current_menu_item !== 6'd11) begin
            $display("FAIL dial got phn %h st %0d cmd %0d item %0d want 04 3 1 11",
                     bus.phn_num, bus.current_state, bus.command, bus.current_menu_item);
            miscompares++;
        end
        bus.s2 = 1'b0;
        pulse_inc(3'd1);
        vectors++;
        if (bus.current_state !== 3'd5 || bus.current_menu_item !== 6'd9 ||
            bus.command !== 3'd0 || bus.phn_num !== 8'h04) begin
            $display("FAIL connected got st %0d item %0d cmd %0d phn %h want 5 9 0 04",
                     bus.current_state, bus.current_menu_item, bus.command, bus.phn_num);
            miscompares++;
        end
    endtask

    task automatic test_voicemail_priority();
        press(BtnDown);
        press(BtnEnter);
        pulse_inc(3'd6);
        press(BtnRight);
        press(BtnDown);
        vectors++;
        if (bus.current_menu_item !== 6'd3) begin
            $display("FAIL menu_down got %0d want 3", bus.current_menu_item); miscompares++;
        end
        bus.enter = 1'b1;
        tick();
        vectors++;
        if (bus.voicemail_command !== 1'b1 || bus.voicemail_status !== 1'b1) begin
            $display("FAIL vm_select got cmd %b st %b want 1 1", bus.voicemail_command,
                     bus.voicemail_status);
            miscompares++;
        end
        bus.enter = 1'b0;
        tick();
        vectors++;
        if (bus.voicemail_command !== 1'b0 || bus.voicemail_status !== 1'b1) begin
            $display("FAIL vm_pulse got cmd %b st %b want 0 1", bus.voicemail_command,
                     bus.voicemail_status);
            miscompares++;
        end
        // Incoming call and enter in the same cycle: the call wins.
        bus.enter = 1'b1;
        bus.inc_command = 3'd5;
        tick();
        vectors++;
        if (bus.current_state !== 3'd4 || bus.current_menu_item !== 6'd6 ||
            bus.voicemail_status !== 1'b1 || bus.voicemail_command !== 1'b0) begin
            $display("FAIL inc_priority got st %0d item %0d vm %b%b want 4 6 10",
                     bus.current_state, bus.current_menu_item, bus.voicemail_status,
                     bus.voicemail_command);
            miscompares++;
        end
        bus.enter = 1'b0;
        bus.inc_command = 3'd0;
        tick();
        pulse_inc(3'd6);
        vectors++;
        if (bus.current_state !== 3'd1 || bus.current_menu_item !== 6'd1) begin
            $display("FAIL incoming_end got st %0d item %0d want 1 1", bus.current_state,
                     bus.current_menu_item);
            miscompares++;
        end
    endtask

    task automatic test_volume();
        for (int i = 0; i < 20; i++) press(BtnB1);
        vectors++;
        if (bus.headphone_volume !== 5'd31) begin
            $display("FAIL vol_saturate got %0d want 31", bus.headphone_volume); miscompares++;
        end
        bus.b0 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.b0 = 1'b0;
        tick();
        vectors++;
        if (bus.headphone_volume !== 5'd30) begin
            $display("FAIL vol_held got %0d want 30", bus.headphone_volume); miscompares++;
        end
        bus.b0 = 1'b1;
        bus.b1 = 1'b1;
        tick();
        vectors++;
        if (bus.headphone_volume !== 5'd30) begin
            $display("FAIL vol_both got %0d want 30", bus.headphone_volume); miscompares++;
        end
        bus.b0 = 1'b0;
        bus.b1 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_call();
        pulse_inc(3'd5);
        press(BtnDown);
        press(BtnEnter);
        vectors++;
        if (bus.current_state !== 3'd5 || bus.command !== 3'd2) begin
            $display("FAIL reach_busy got st %0d cmd %0d want 5 2", bus.current_state,
                     bus.command);
            miscompares++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (bus.current_state !== 3'd0 || bus.current_menu_item !== 6'd0 ||
            bus.command !== 3'd0 || bus.headphone_volume !== 5'd16) begin
            $display("FAIL mid_reset got st %0d item %0d cmd %0d vol %0d want 0 0 0 16",
                     bus.current_state, bus.current_menu_item, bus.command,
                     bus.headphone_volume);
            miscompares++;
        end
        press(BtnB1);
        vectors++;
        if (bus.headphone_volume !== 5'd16) begin
            $display("FAIL vol_in_init got %0d want 16", bus.headphone_volume); miscompares++;
        end
        press(BtnInit);
        vectors++;
        if (bus.current_state !== 3'd1 || bus.current_menu_item !== 6'd1) begin
            $display("FAIL init_edge got st %0d item %0d want 1 1", bus.current_state,
                     bus.current_menu_item);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        {bus.s7, bus.s6, bus.s5, bus.s4, bus.s3, bus.s2, bus.s1, bus.s0} = 8'd0;
        {bus.b3, bus.b2, bus.b1, bus.b0} = 4'd0;
        {bus.enter, bus.up, bus.down, bus.left, bus.right, bus.init} = 6'd0;
        bus.inc_command = 3'd0;

        test_reset();
        test_enter_idle();
        test_incoming_accept();
        test_busy_end();
        test_dial();
        test_voicemail_priority();
        test_volume();
        test_reset_mid_call();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
